// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_stage                                                  |
// | Description : Instruction fetch with req/ack memory handshake, stall hold  |
// |               buffer, branch redirect/drain, and the IF/ID register.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                HDR_MSB  = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Stall,
  input  logic              BranchTaken,
  input  logic [ADDR_W-1:0] BranchTarget,
  output logic              ImemReq,
  output logic [ADDR_W-1:0] ImemAddr,
  input  logic              ImemAck,
  input  logic [DATA_W-1:0] ImemData,
  output logic [DATA_W-1:0] InstD,
  output logic [9:0]        InstHeader,
  output logic [ADDR_W-1:0] PCD,
  output logic [ADDR_W-1:0] PCPlus4D,
  output logic              ValidD
);

  localparam logic [ADDR_W-1:0] c_pcStep = ADDR_W'(4);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetchState_t;

  fetchState_t       r_state;
  fetchState_t       w_nextState;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_drainAddr;   // address of the request abandoned by a redirect
  logic [DATA_W-1:0] r_holdInst;
  logic [ADDR_W-1:0] r_holdPc;
  logic              r_holdFull;

  logic [ADDR_W-1:0] w_pcNext;
  logic              w_loadFromMem;
  logic              w_loadFromHold;
  logic              w_bubble;
  logic              w_holdWrite;
  logic              w_holdClear;
  logic              w_drainCapture;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= FETCH;
    else      r_state <= w_nextState;
  end

  // Next state, memory interface and datapath control; redirect has top priority
  always_comb begin
    w_nextState    = r_state;
    w_pcNext       = r_pc;
    ImemReq        = 1'b0;
    ImemAddr       = r_pc;
    w_loadFromMem  = 1'b0;
    w_loadFromHold = 1'b0;
    w_bubble       = 1'b0;
    w_holdWrite    = 1'b0;
    w_holdClear    = 1'b0;
    w_drainCapture = 1'b0;
    case (r_state)
      FETCH: begin
        ImemReq = 1'b1;
        if (BranchTaken) begin
          w_pcNext    = BranchTarget;
          w_bubble    = 1'b1;
          w_holdClear = 1'b1;
          // An un-acked request must still complete before the target is fetched
          if (!ImemAck) begin
            w_nextState    = DRAIN;
            w_drainCapture = 1'b1;
          end
        end else if (ImemAck) begin
          w_pcNext = r_pc + c_pcStep;
          if (!Stall) begin
            w_loadFromMem = 1'b1;
          end else begin
            w_holdWrite = 1'b1;
            w_nextState = HOLD;
          end
        end else if (!Stall) begin
          w_bubble = 1'b1;
        end
      end
      HOLD: begin
        if (BranchTaken) begin
          w_pcNext    = BranchTarget;
          w_bubble    = 1'b1;
          w_holdClear = 1'b1;
          w_nextState = FETCH;
        end else if (!Stall) begin
          w_loadFromHold = 1'b1;
          w_nextState    = FETCH;
        end
      end
      DRAIN: begin
        ImemReq  = 1'b1;
        ImemAddr = r_drainAddr;
        if (BranchTaken) begin
          w_pcNext    = BranchTarget;
          w_bubble    = 1'b1;
          w_holdClear = 1'b1;
        end else if (ImemAck) begin
          w_nextState = FETCH;
        end
      end
      default: begin
        w_nextState = FETCH;
      end
    endcase
  end

  // PC, drain address, hold buffer and IF/ID register updates
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc        <= RESET_PC;
      r_drainAddr <= RESET_PC;
      r_holdInst  <= '0;
      r_holdPc    <= '0;
      r_holdFull  <= 1'b0;
      InstD       <= '0;
      PCD         <= '0;
      PCPlus4D    <= '0;
      ValidD      <= 1'b0;
    end else begin
      r_pc <= w_pcNext;
      if (w_drainCapture) r_drainAddr <= r_pc;
      if (w_holdWrite) begin
        r_holdInst <= ImemData;
        r_holdPc   <= r_pc;
        r_holdFull <= 1'b1;
      end else if (w_holdClear || w_loadFromHold) begin
        r_holdFull <= 1'b0;
      end
      if (w_loadFromMem) begin
        InstD    <= ImemData;
        PCD      <= r_pc;
        PCPlus4D <= r_pc + c_pcStep;
        ValidD   <= 1'b1;
      end else if (w_loadFromHold) begin
        InstD    <= r_holdInst;
        PCD      <= r_holdPc;
        PCPlus4D <= r_holdPc + c_pcStep;
        ValidD   <= r_holdFull;
      end else if (w_bubble) begin
        ValidD <= 1'b0;
      end
    end
  end

  assign InstHeader = InstD[HDR_MSB -: 10];

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fetch_stage                                               |
// | Description : Directed vector bench for fetch_stage.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemData;
  logic [31:0] InstD;
  logic [9:0]  InstHeader;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;

  int checks   = 0;
  int failures = 0;

  fetch_stage #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .RESET_PC(32'h0000_0000),
    .HDR_MSB (31)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .Stall       (Stall),
    .BranchTaken (BranchTaken),
    .BranchTarget(BranchTarget),
    .ImemReq     (ImemReq),
    .ImemAddr    (ImemAddr),
    .ImemAck     (ImemAck),
    .ImemData    (ImemData),
    .InstD       (InstD),
    .InstHeader  (InstHeader),
    .PCD         (PCD),
    .PCPlus4D    (PCPlus4D),
    .ValidD      (ValidD)
  );

  always #5 clk = ~clk;

  // Memory contents: word at address a is 0x0080_0000 + a
  assign ImemData = 32'h0080_0000 + ImemAddr;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return 32'h0080_0000 + a;
  endfunction

  typedef struct {
    logic        rstN;
    logic        stall;
    logic        br;
    logic [31:0] target;
    logic        ack;
    logic [1:0]  chk;      // bit1: check ImemReq, bit0: check ImemAddr
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expPcd;
    logic [31:0] expInst;
    logic [31:0] expPc4;
  } vec_t;

  function automatic vec_t mk(input logic rstN, input logic stall, input logic br,
                              input logic [31:0] target, input logic ack,
                              input logic [1:0] chk, input logic expReq,
                              input logic [31:0] expAddr, input logic expValid,
                              input logic [31:0] expPcd, input logic [31:0] expInst,
                              input logic [31:0] expPc4);
    vec_t v;
    v.rstN = rstN; v.stall = stall; v.br = br; v.target = target; v.ack = ack;
    v.chk = chk; v.expReq = expReq; v.expAddr = expAddr; v.expValid = expValid;
    v.expPcd = expPcd; v.expInst = expInst; v.expPc4 = expPc4;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  // One cycle: drive at negedge, check request side before the edge, IF/ID after it
  task automatic applyVec(input vec_t v, input int idx);
    logic [31:0] hdr;
    @(negedge clk);
    rst          = v.rstN;
    Stall        = v.stall;
    BranchTaken  = v.br;
    BranchTarget = v.target;
    ImemAck      = v.ack;
    #1;
    if (v.chk[1]) check("ImemReq", idx, {31'd0, ImemReq}, {31'd0, v.expReq});
    if (v.chk[0]) check("ImemAddr", idx, ImemAddr, v.expAddr);
    @(posedge clk);
    #1;
    hdr = v.expInst;
    check("ValidD", idx, {31'd0, ValidD}, {31'd0, v.expValid});
    check("PCD", idx, PCD, v.expPcd);
    check("InstD", idx, InstD, v.expInst);
    check("PCPlus4D", idx, PCPlus4D, v.expPc4);
    check("InstHeader", idx, {22'd0, InstHeader}, {22'd0, hdr[31:22]});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    logic [31:0] top;
    top = 32'hFFFF_FFFC;
    rst = 1'b0; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = '0; ImemAck = 1'b0;

    // Reset
    vecs.push_back(mk(0,0,0,0,0,2'b00,0,0,         0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,2'b11,1,0,         0,0,0,0));
    // Zero-wait stream
    vecs.push_back(mk(1,0,0,0,1,2'b11,1,0,         1,0,memWord(0),4));
    vecs.push_back(mk(1,0,0,0,1,2'b11,1,4,         1,4,memWord(4),8));
    // Three wait states at address 8
    vecs.push_back(mk(1,0,0,0,0,2'b11,1,8,         0,4,memWord(4),8));
    vecs.push_back(mk(1,0,0,0,0,2'b11,1,8,         0,4,memWord(4),8));
    vecs.push_back(mk(1,0,0,0,0,2'b11,1,8,         0,4,memWord(4),8));
    vecs.push_back(mk(1,0,0,0,1,2'b11,1,8,         1,8,memWord(8),12));
    // Stall beginning with the ack for 12; stray ack during HOLD is ignored
    vecs.push_back(mk(1,1,0,0,1,2'b11,1,12,        1,8,memWord(8),12));
    vecs.push_back(mk(1,1,0,0,1,2'b10,0,0,         1,8,memWord(8),12));
    vecs.push_back(mk(1,1,0,0,0,2'b10,0,0,         1,8,memWord(8),12));
    vecs.push_back(mk(1,1,0,0,0,2'b10,0,0,         1,8,memWord(8),12));
    vecs.push_back(mk(1,0,0,0,0,2'b10,0,0,         1,12,memWord(12),16));
    vecs.push_back(mk(1,0,0,0,1,2'b11,1,16,        1,16,memWord(16),20));
    // Redirect with request to 20 outstanding
    vecs.push_back(mk(1,0,1,32'h100,0,2'b11,1,20,  0,16,memWord(16),20));
    vecs.push_back(mk(1,0,0,0,0,2'b11,1,20,        0,16,memWord(16),20));
    vecs.push_back(mk(1,0,0,0,1,2'b11,1,20,        0,16,memWord(16),20));
    vecs.push_back(mk(1,0,0,0,1,2'b11,1,32'h100,   1,32'h100,memWord(32'h100),32'h104));
    // Branch and stall together while in HOLD
    vecs.push_back(mk(1,1,0,0,1,2'b11,1,32'h104,   1,32'h100,memWord(32'h100),32'h104));
    vecs.push_back(mk(1,1,1,32'h200,0,2'b10,0,0,   0,32'h100,memWord(32'h100),32'h104));
    vecs.push_back(mk(1,0,0,0,1,2'b11,1,32'h200,   1,32'h200,memWord(32'h200),32'h204));
    // Branch coinciding with an ack drops the data; then PC wrap
    vecs.push_back(mk(1,0,1,top,1,2'b11,1,32'h204, 0,32'h200,memWord(32'h200),32'h204));
    vecs.push_back(mk(1,0,0,0,1,2'b11,1,top,       1,top,memWord(top),0));
    vecs.push_back(mk(1,0,0,0,0,2'b11,1,0,         0,top,memWord(top),0));
    // Reset while in DRAIN
    vecs.push_back(mk(1,0,1,32'h300,0,2'b11,1,0,   0,top,memWord(top),0));
    vecs.push_back(mk(0,0,0,0,0,2'b11,1,0,         0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,2'b11,1,0,         0,0,0,0));

    for (int i = 0; i < vecs.size(); i++) applyVec(vecs[i], i);

    // Hand sequence: second redirect while already draining retargets the PC
    applyVec(mk(1,0,1,32'h400,0,2'b11,1,0,         0,0,0,0), 100);
    applyVec(mk(1,0,1,32'h500,0,2'b11,1,0,         0,0,0,0), 101);
    applyVec(mk(1,0,0,0,1,2'b11,1,0,               0,0,0,0), 102);
    applyVec(mk(1,0,0,0,1,2'b11,1,32'h500,         1,32'h500,memWord(32'h500),32'h504), 103);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
